// File: rtl/tx_align_pattern_gen.sv
// Transmit-side bit-alignment companion: emits training bursts, user data or idle words as P/~N pairs.
// Define TX_PRBS7_EN to source training words from a PRBS7 LFSR instead of the fixed alternating pattern.
module tx_align_pattern_gen #(
   parameter int         TRAIN_WORDS   = 1024,
   parameter logic [7:0] TRAIN_PATTERN = 8'hB4,
   parameter logic [7:0] IDLE_WORD     = 8'h9C
) (
   input  logic        clk160,
   input  logic        totalCounterResetb_manual,
   input  logic        tx_enable,
   input  logic        train_req,
   input  logic        train_continuous,
   input  logic        err_inject,
   input  logic        reset_counters,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [7:0]  D_IN_P,
   output logic [7:0]  D_IN_N,
   output logic        training_active,
   output logic        train_done,
   output logic [15:0] words_sent
);
   localparam int               CNT_W    = $clog2(TRAIN_WORDS) + 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TRAIN_WORDS - 1);

   typedef enum logic [1:0] {ST_OFF, ST_IDLE, ST_TRAIN, ST_DONE} state_t;

   state_t           state;
   logic [2:0]       req_sr;
   logic [CNT_W-1:0] cnt;
   logic             req_rise;
   logic             going_off;
   logic             train_start;
   logic             train_end;
   logic             inject;
   logic [7:0]       start_word;
   logic [7:0]       cont_word;
   logic [7:0]       p_next;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign req_rise    = (req_sr[2:1] == 2'b01);
   assign going_off   = !tx_enable || (state == ST_OFF);
   assign train_start = req_rise && tx_enable && ((state == ST_IDLE) || (state == ST_TRAIN));
   assign train_end   = (state == ST_TRAIN) && !req_rise && (cnt == '0) && !train_continuous;
   assign s_ready     = tx_enable && (state == ST_IDLE) && !req_rise;
   assign inject      = err_inject && !going_off;

`ifdef TX_PRBS7_EN
   logic [6:0]  lfsr;
   logic [14:0] prbs_seed;
   logic [14:0] prbs_cont;

   // Returns {word, next LFSR state}; the first bit shifted out lands in word[7].
   function automatic logic [14:0] prbs7_word(input logic [6:0] seed);
      logic [6:0] s;
      logic [7:0] w;
      s = seed;
      w = '0;
      for (int i = 0; i < 8; i++) begin
         w = {w[6:0], s[6]};
         s = {s[5:0], s[6] ^ s[5]};
      end
      return {w, s};
   endfunction

   assign prbs_seed  = prbs7_word(7'h7F);
   assign prbs_cont  = prbs7_word(lfsr);
   assign start_word = prbs_seed[14:7];
   assign cont_word  = prbs_cont[14:7];

   always_ff @(posedge clk160 or negedge totalCounterResetb_manual) begin
      if (!totalCounterResetb_manual)
         lfsr <= 7'h7F;
      else if (train_start)
         lfsr <= prbs_seed[6:0];
      else if ((state == ST_TRAIN) && !going_off)
         lfsr <= prbs_cont[6:0];
   end
`else
   logic odd;

   assign start_word = TRAIN_PATTERN;
   assign cont_word  = odd ? ~TRAIN_PATTERN : TRAIN_PATTERN;

   always_ff @(posedge clk160 or negedge totalCounterResetb_manual) begin
      if (!totalCounterResetb_manual)
         odd <= 1'b0;
      else if (train_start)
         odd <= 1'b1;
      else if ((state == ST_TRAIN) && !going_off)
         odd <= ~odd;
   end
`endif

   // A training request outranks a data word offered in the same cycle.
   always_comb begin
      p_next = 8'h00;
      if (!going_off) begin
         case (state)
            ST_IDLE:  p_next = train_start ? start_word : (s_valid ? s_data : IDLE_WORD);
            ST_TRAIN: p_next = train_start ? start_word : (train_end ? IDLE_WORD : cont_word);
            default:  p_next = IDLE_WORD;
         endcase
      end
   end

   always_ff @(posedge clk160 or negedge totalCounterResetb_manual) begin
      if (!totalCounterResetb_manual) begin
         state           <= ST_OFF;
         req_sr          <= 3'b000;
         cnt             <= '0;
         D_IN_P          <= 8'h00;
         D_IN_N          <= 8'hFF;
         training_active <= 1'b0;
         train_done      <= 1'b0;
         words_sent      <= 16'h0000;
      end else begin
         req_sr          <= {req_sr[1:0], train_req};
         D_IN_P          <= p_next;
         D_IN_N          <= ~p_next ^ {7'b0, inject};
         training_active <= 1'b0;
         train_done      <= 1'b0;

         if (reset_counters)
            words_sent <= 16'h0000;
         else if (s_valid && s_ready)
            words_sent <= sat_inc(words_sent);

         if (!tx_enable) begin
            state <= ST_OFF;
         end else begin
            case (state)
               ST_OFF: state <= ST_IDLE;
               ST_IDLE: begin
                  if (train_start) begin
                     state           <= ST_TRAIN;
                     cnt             <= CNT_LOAD;
                     training_active <= 1'b1;
                  end
               end
               ST_TRAIN: begin
                  if (train_start) begin
                     cnt             <= CNT_LOAD;
                     training_active <= 1'b1;
                  end else if (train_end) begin
                     state      <= ST_DONE;
                     train_done <= 1'b1;
                  end else begin
                     if (cnt != '0)
                        cnt <= cnt - 1'b1;
                     training_active <= 1'b1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/tx_align_pattern_gen.md
Name: tx_align_pattern_gen

Overview:
Transmit-side companion to the receive-side IDELAY bit-alignment controller. It drives the 8-bit parallel P/N words into the output serializers. It supplies a transition-rich training burst on request so the far-end receiver can scan its delay taps, and otherwise forwards user data or an idle word. N is always the bitwise complement of P, which is what the receiver's P/N error check expects. A single-word error-injection hook lets the receiver's bit-align error counter be exercised end to end.

Parameters:
TRAIN_WORDS, 1024, number of words in one training burst (minimum 1).
TRAIN_PATTERN, 8'hB4, fixed training word; even words carry TRAIN_PATTERN, odd words carry ~TRAIN_PATTERN.
IDLE_WORD, 8'h9C, word sent when enabled and there is no data and no training.

Ports:
clk160  in  1  system clock.
totalCounterResetb_manual  in  1  asynchronous active-low reset.
tx_enable  in  1  level; 0 forces the OFF state.
train_req  in  1  asynchronous level; a rising edge starts a training burst.
train_continuous  in  1  1 = keep training past TRAIN_WORDS until this input drops.
err_inject  in  1  single-cycle pulse; corrupts the next output word.
reset_counters  in  1  synchronous clear of words_sent.
s_data  in  8  upstream data word.
s_valid  in  1  upstream word valid.
s_ready  out  1  block accepts s_data this cycle.
D_IN_P  out  8  P word to the serializer; D_IN_P[7] is serialized first.
D_IN_N  out  8  N word to the serializer; nominally ~D_IN_P.
training_active  out  1  1 while in the TRAIN state.
train_done  out  1  one-cycle pulse at the end of a finite burst.
words_sent  out  16  count of accepted data words; saturates at 16'hFFFF.

Behaviour:
- All outputs are registered except s_ready.
- Reset values:
  - state OFF
  - D_IN_P = 8'h00, D_IN_N = 8'hFF
  - training_active = 0, train_done = 0, words_sent = 0
  - s_ready = 0
  - 3-bit train_req synchroniser = 0
- train_req synchroniser: req_sr <= {req_sr[1:0], train_req}. Edge is detected when req_sr[2:1] == 2'b01.
- States: OFF, IDLE, TRAIN, DONE. tx_enable == 0 has top priority and moves any state to OFF on the next edge.
- OFF:
  - D_IN_P = 00, D_IN_N = FF, s_ready = 0.
  - Go to IDLE when tx_enable = 1.
  - train_req edges are ignored.
- IDLE:
  - s_ready = 1.
  - If s_valid, the word is registered onto D_IN_P on the next edge (latency 1) and words_sent increments.
  - Otherwise D_IN_P <= IDLE_WORD.
  - A train_req edge moves the state to TRAIN and takes priority over data: s_ready is forced to 0 in the detect cycle, and the word counter loads TRAIN_WORDS-1.
- TRAIN:
  - s_ready = 0, training_active = 1.
  - The first pattern word appears on the same edge the state enters TRAIN.
  - The counter decrements once per word.
  - When the counter is 0 and train_continuous = 0, go to DONE.
  - When the counter is 0 and train_continuous = 1, the counter holds at 0 and the pattern continues.
  - A new train_req edge during TRAIN reloads the counter and restarts the pattern phase at the even word.
- DONE: train_done = 1 for exactly one cycle, D_IN_P <= IDLE_WORD, then go to IDLE.
- Leaving TRAIN through OFF (tx_enable drop mid-burst) produces no train_done pulse.
- D_IN_N:
  - D_IN_N <= ~D_IN_P_next every cycle, except on the word after an err_inject pulse, where D_IN_N[0] = D_IN_P_next[0].
  - This creates exactly one receiver-detected bit-align error.
  - err_inject is honoured in IDLE, TRAIN and DONE, and is dropped in OFF.
- words_sent:
  - Increments only on s_valid && s_ready.
  - Saturates at FFFF.
  - reset_counters has priority over an increment in the same cycle.
- Counter width is $clog2(TRAIN_WORDS)+1 bits.

Optional Feature:
TX_PRBS7_EN:
- Defined: training words come from a PRBS7 LFSR (x^7+x^6+1).
  - The state s[6:0] is seeded to 7'h7F on every entry to or restart of TRAIN.
  - Each step outputs s[6], then s <= {s[5:0], s[6]^s[5]}.
  - The LFSR advances 8 steps per word; the first output bit goes to D_IN_P[7].
  - First word = 8'hFE. The PRBS sequence continues regardless of word parity.
- Undefined: the fixed alternating TRAIN_PATTERN / ~TRAIN_PATTERN is used, and no LFSR logic is present.

Test Plan:
1. Reset released, tx_enable=1, s_valid=0 -> D_IN_P=9C, D_IN_N=63, s_ready=1, words_sent=0.
2. TRAIN_WORDS=4, pulse train_req -> D_IN_P = B4,4B,B4,4B with training_active=1; then train_done for 1 cycle with D_IN_P=9C; back in IDLE.
3. In IDLE, s_valid with 11 then 22 -> D_IN_P=11,22 one cycle later, words_sent=2. During TRAIN s_ready=0 and no words are accepted. reset_counters together with an accepted word -> words_sent=0.
4. err_inject pulse in IDLE -> next word has D_IN_P=9C, D_IN_N=62; the following word is back to 63.
5. train_continuous=1, TRAIN_WORDS=4 -> pattern runs past 4 words until train_continuous drops, then DONE. Separately, drop tx_enable mid-burst -> OFF next edge with P=00, N=FF, no train_done.
6. With TX_PRBS7_EN defined, start training -> first word D_IN_P=FE, N=01; a restart via train_req reseeds so FE appears again.
